encoder8_3_arb: RTL and testbench
=================================

Name: encoder8_3_arb

Overview:
- Reverse of the 3-to-8 select decoder: takes eight single-cycle request strobes (in0..in7) and returns one 3-bit index `sel` per granted request.
- Requests are held in a pending register. They are presented one at a time on a valid/ready handshake.
- Sits between event sources (interrupt or unit-done lines) and the CPU control logic, which consumes `sel` to index the originating unit.

Parameters:
- PRIO_LOW_FIRST, 1: 1 = index 0 has highest priority; 0 = index 7 has highest priority. Applies in fixed-priority mode only.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in0..in7  in  1 each  request strobes; each high cycle counts as one request
- ready  in  1  consumer accepts `sel` this cycle when `valid`=1
- sel  out  3  encoded index of the presented request
- valid  out  1  `sel` is meaningful and is held until accepted
- err  out  1  one-cycle pulse: a request was merged into an already-pending one
- busy  out  1  |pending OR valid

Behaviour:
- Reset (async assert, sync deassert handled upstream): pending=8'h00, sel=3'd0, valid=0, err=0, state=IDLE, rr_ptr=3'd7.
- Define req = {in7..in0} and cand = pending | req.
- Two states: IDLE (valid=0) and HOLD (valid=1).
- Load:
  - In IDLE, or in HOLD with ready=1, if cand != 0: select index k from cand.
  - Next cycle: sel=k, valid=1, state=HOLD.
  - pending <= (cand & ~(1<<k)).
- Hold:
  - HOLD with ready=0: sel and valid are frozen, and pending <= cand.
  - `sel` must never change while valid=1 and ready=0.
- Release: HOLD with ready=1 and cand=0 -> valid=0, state=IDLE next cycle; sel keeps its last value.
- Latency and throughput:
  - A strobe on in_i in cycle N with an idle output gives valid=1, sel=i in cycle N+1.
  - Back-to-back grants run at one per cycle while ready=1.
- Overlap:
  - If in_i=1 and pending[i]=1 in the same cycle, the requests merge (one grant) and err=1 in the next cycle only.
  - A strobe on in_i while the output holds sel=i unaccepted is not an overlap; it sets pending[i].
- Simultaneous strobes: all are captured; they are granted in priority order over successive handshakes.
- Fixed priority:
  - PRIO_LOW_FIRST=1: lowest set index in cand wins.
  - PRIO_LOW_FIRST=0: highest set index wins.
- busy is combinational from registers: |pending | valid.
- Reset asserted mid-operation: all pending requests and the presented request are discarded immediately. No grant appears after deassertion until a new strobe arrives.

Optional Feature:
- Macro: ENCODER8_3_ROUND_ROBIN_EN.
- Defined:
  - Priority rotates. The search starts at (rr_ptr+1) mod 8 and wraps upward.
  - rr_ptr <= k on each load; rr_ptr resets to 7, so the first search starts at 0.
  - PRIO_LOW_FIRST is ignored.
- Undefined: fixed priority per PRIO_LOW_FIRST; rr_ptr is not implemented.

Decomposition:
- Shared package decoder_pkg:
  - N_LINES=8 and SEL_W=3. These constants are shared with the 3-to-8 decoder.
  - State enum {IDLE, HOLD}.
- One sub-module, prio_enc8 (combinational):
  - Inputs: 8-bit mask, 3-bit start index, direction bit.
  - Outputs: 3-bit idx and found.
  - Instantiated once. In round-robin mode the start is rr_ptr+1; in fixed mode it is 0 or 7.

Test Plan:
- Reset then single strobe: in3=1 for one cycle with ready=1 -> next cycle valid=1, sel=3; following cycle valid=0, busy=0, err=0.
- Simultaneous strobes: in1, in5 and in6 in one cycle, ready=1, fixed priority with PRIO_LOW_FIRST=1 -> sel=1, 5, 6 on three consecutive cycles, then valid=0.
- Backpressure: in2 strobe with ready=0 for 4 cycles -> sel=2 and valid=1 stable for all 4 cycles. An in0 strobe during the hold sets pending. Raising ready -> sel=0 on the cycle after acceptance.
- Overlap: in4 strobed in two separate cycles while the output holds sel=7 with ready=0 -> err=1 for exactly one cycle after the second strobe; exactly one later grant with sel=4.
- Round robin (macro defined): pending all 8'hFF with ready=1 -> sel sequence 0,1,...,7. A fresh in0 and in7 strobe after grant 7 -> sel=0 then 7. Repeat with grant 2 last and in0/in7 pending -> sel=7 then 0.
- Async reset mid-hold: rst_n low while valid=1 with pending=8'h30 -> valid, err and busy go to 0 without waiting for a clock edge. After release, no grant occurs until a new strobe.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - constants and types shared by the 3-to-8 decoder and the 8-to-3 arbiter
package decoder_pkg;

    localparam int N_LINES = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot line mask for an encoded index.
    function automatic logic [N_LINES-1:0] line_mask(input logic [SEL_W-1:0] idx);
        line_mask      = '0;
        line_mask[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/encoder8_3_arb_prio_enc8.sv
// rtl/encoder8_3_arb_prio_enc8.sv - circular priority encoder over eight lines
// mask  : candidate lines
// start : first index examined
// dir   : 1 = search upward from start, 0 = search downward, both wrapping mod 8
// idx   : first set line found in search order
// found : mask has at least one bit set
module prio_enc8
    import decoder_pkg::*;
(
    input  logic [N_LINES-1:0] mask,
    input  logic [SEL_W-1:0]   start,
    input  logic               dir,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] pos;

    // Walk from the farthest position toward start so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            pos = dir ? (start + SEL_W'(i)) : (start - SEL_W'(i));
            if (mask[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder8_3_arb.sv
// rtl/encoder8_3_arb.sv - 8-to-3 request encoder with pending store and valid/ready output
// Build option ENCODER8_3_ROUND_ROBIN_EN: rotating priority instead of fixed priority.
// clk, rst_n : clock, asynchronous active-low reset
// in0..in7   : single-cycle request strobes
// ready      : consumer accepts sel while valid
// sel, valid : presented index, held until accepted
// err        : one-cycle pulse when a strobe merged into an already-pending request
// busy       : pending requests or a presented request exist
module encoder8_3_arb
    import decoder_pkg::*;
#(
    parameter bit PRIO_LOW_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    input  logic             in4,
    input  logic             in5,
    input  logic             in6,
    input  logic             in7,
    input  logic             ready,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             err,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               err_q, err_d;
    logic [N_LINES-1:0] req, cand;
    logic [SEL_W-1:0]   start, k;
    logic               dir, found;

    assign req  = {in7, in6, in5, in4, in3, in2, in1, in0};
    assign cand = pending_q | req;

`ifdef ENCODER8_3_ROUND_ROBIN_EN
    logic [SEL_W-1:0] rr_q, rr_d;

    // Search starts just past the last granted line; reset value 7 makes the first search start at 0.
    assign start = rr_q + SEL_W'(1);
    assign dir   = 1'b1;
`else
    assign start = PRIO_LOW_FIRST ? SEL_W'(0) : SEL_W'(N_LINES - 1);
    assign dir   = PRIO_LOW_FIRST;
`endif

    prio_enc8 u_prio_enc8 (
        .mask  (cand),
        .start (start),
        .dir   (dir),
        .idx   (k),
        .found (found)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = cand;
        sel_d     = sel_q;
        // Granted lines are cleared from pending, so a strobe on the presented line is not a merge.
        err_d     = |(req & pending_q);
`ifdef ENCODER8_3_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        if (state_q == IDLE || ready) begin
            if (found) begin
                state_d   = HOLD;
                sel_d     = k;
                pending_d = cand & ~line_mask(k);
`ifdef ENCODER8_3_ROUND_ROBIN_EN
                rr_d      = k;
`endif
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            sel_q     <= '0;
            err_q     <= 1'b0;
`ifdef ENCODER8_3_ROUND_ROBIN_EN
            rr_q      <= SEL_W'(N_LINES - 1);
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
`ifdef ENCODER8_3_ROUND_ROBIN_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign sel   = sel_q;
    assign valid = (state_q == HOLD);
    assign err   = err_q;
    assign busy  = (|pending_q) | valid;

endmodule

// File: tb/tb_encoder8_3_arb.sv
// tb/tb_encoder8_3_arb.sv - self-checking bench for encoder8_3_arb
module tb_encoder8_3_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_v = 8'h00;
    logic       ready = 1'b0;
    logic [2:0] sel;
    logic       valid, err, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    encoder8_3_arb #(.PRIO_LOW_FIRST(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (req_v[0]),
        .in1   (req_v[1]),
        .in2   (req_v[2]),
        .in3   (req_v[3]),
        .in4   (req_v[4]),
        .in5   (req_v[5]),
        .in6   (req_v[6]),
        .in7   (req_v[7]),
        .ready (ready),
        .sel   (sel),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    // Reference model: a set of outstanding request lines plus the presented grant.
    bit m_pend [8];
    int m_sel;
    bit m_valid;
    bit m_err;
    int m_rr;

    function automatic int pick();
`ifdef ENCODER8_3_ROUND_ROBIN_EN
        for (int off = 1; off <= 8; off++)
            if (m_pend[(m_rr + off) % 8]) return (m_rr + off) % 8;
`else
        for (int i = 0; i < 8; i++)
            if (m_pend[i]) return i;
`endif
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_sel = 0; m_valid = 1'b0; m_err = 1'b0; m_rr = 7;
        end else begin
            int k;
            m_err = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (req_v[i] && m_pend[i]) m_err = 1'b1;
                if (req_v[i]) m_pend[i] = 1'b1;
            end
            if (!m_valid || ready) begin
                k = pick();
                if (k < 0) m_valid = 1'b0;
                else begin
                    m_sel = k; m_valid = 1'b1; m_pend[k] = 1'b0; m_rr = k;
                end
            end
        end
    end

    function automatic bit model_busy();
        for (int i = 0; i < 8; i++) if (m_pend[i]) return 1'b1;
        return m_valid;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid", int'(valid), int'(m_valid));
            chk("model_err", int'(err), int'(m_err));
            chk("model_busy", int'(busy), int'(model_busy()));
            if (m_valid) chk("model_sel", int'(sel), m_sel);
        end
    end

    task automatic step(input logic [7:0] r, input logic rdy);
        req_v = r;
        ready = rdy;
        @(posedge clk);
        #1;
        req_v = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_valid", int'(valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_sel", int'(sel), 0);

        // Single strobe
        step(8'h08, 1'b1);
        chk("single_valid", int'(valid), 1);
        chk("single_sel", int'(sel), 3);
        step(8'h00, 1'b1);
        chk("single_idle_valid", int'(valid), 0);
        chk("single_idle_busy", int'(busy), 0);
        chk("single_idle_err", int'(err), 0);

        // Simultaneous strobes on 1, 5, 6
        step(8'h62, 1'b1);
`ifdef ENCODER8_3_ROUND_ROBIN_EN
        chk("simul_sel0", int'(sel), 5);
        step(8'h00, 1'b1);
        chk("simul_sel1", int'(sel), 6);
        step(8'h00, 1'b1);
        chk("simul_sel2", int'(sel), 1);
`else
        chk("simul_sel0", int'(sel), 1);
        step(8'h00, 1'b1);
        chk("simul_sel1", int'(sel), 5);
        step(8'h00, 1'b1);
        chk("simul_sel2", int'(sel), 6);
`endif
        step(8'h00, 1'b1);
        chk("simul_done", int'(valid), 0);

        // Backpressure with a strobe arriving during the hold
        step(8'h04, 1'b0);
        chk("bp_sel_c1", int'(sel), 2);
        step(8'h01, 1'b0);
        chk("bp_sel_c2", int'(sel), 2);
        chk("bp_busy", int'(busy), 1);
        step(8'h00, 1'b0);
        chk("bp_sel_c3", int'(sel), 2);
        step(8'h00, 1'b0);
        chk("bp_sel_c4", int'(sel), 2);
        chk("bp_valid_c4", int'(valid), 1);
        step(8'h00, 1'b1);
        chk("bp_next_sel", int'(sel), 0);
        chk("bp_next_valid", int'(valid), 1);
        step(8'h00, 1'b1);
        chk("bp_done", int'(valid), 0);

        // Overlap: in4 strobed twice while sel=7 is held
        step(8'h80, 1'b0);
        chk("ov_hold_sel", int'(sel), 7);
        step(8'h10, 1'b0);
        chk("ov_first_err", int'(err), 0);
        step(8'h00, 1'b0);
        step(8'h10, 1'b0);
        chk("ov_err_pulse", int'(err), 1);
        step(8'h00, 1'b0);
        chk("ov_err_clear", int'(err), 0);
        step(8'h00, 1'b1);
        chk("ov_grant_sel", int'(sel), 4);
        chk("ov_grant_valid", int'(valid), 1);
        step(8'h00, 1'b1);
        chk("ov_single_grant", int'(valid), 0);
        chk("ov_busy", int'(busy), 0);

`ifdef ENCODER8_3_ROUND_ROBIN_EN
        // Rotation from a fresh reset pointer
        do_reset();
        step(8'hFF, 1'b1);
        chk("rr_seq0", int'(sel), 0);
        for (int i = 1; i < 8; i++) begin
            step(8'h00, 1'b1);
            chk("rr_seq", int'(sel), i);
        end
        step(8'h81, 1'b1);
        chk("rr_wrap_a0", int'(sel), 0);
        step(8'h00, 1'b1);
        chk("rr_wrap_a1", int'(sel), 7);
        step(8'h00, 1'b1);
        chk("rr_wrap_idle", int'(valid), 0);
        step(8'h04, 1'b1);
        chk("rr_grant2", int'(sel), 2);
        step(8'h81, 1'b1);
        chk("rr_wrap_b0", int'(sel), 7);
        step(8'h00, 1'b1);
        chk("rr_wrap_b1", int'(sel), 0);
        step(8'h00, 1'b1);
        chk("rr_wrap_b_idle", int'(valid), 0);
`endif

        // Asynchronous reset while holding with pending = 8'h30
        step(8'h04, 1'b0);
        step(8'h30, 1'b0);
        chk("ar_pre_valid", int'(valid), 1);
        chk("ar_pre_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(valid), 0);
        chk("ar_err", int'(err), 0);
        chk("ar_busy", int'(busy), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b1);
            chk("ar_no_grant", int'(valid), 0);
        end
        step(8'h40, 1'b1);
        chk("ar_new_sel", int'(sel), 6);
        chk("ar_new_valid", int'(valid), 1);
        step(8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
